// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 scan sequencer.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_PAUSE
   } ps2_seq_state_e;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       back;
   } ps2_key_evt_t;

   localparam int unsigned PS2_EVT_W = $bits(ps2_key_evt_t);

   // Device status/response bytes that never start a key sequence.
   function automatic logic ps2_is_status(input logic [7:0] b);
      return (b == PS2_ERR0)   || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
             (b == PS2_ACK)    || (b == PS2_RESEND) || (b == PS2_ERR1);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO for key events; push while full is dropped unless a pop frees the slot.
module ps2_event_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_rd;
   logic             w_wr;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_rd      = i_pop & ~o_empty;
   assign w_wr      = i_push & (~o_full | w_rd);

   // Storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr && !w_rd)      r_count <= r_count + CNT_W'(1);
         else if (w_rd && !w_wr) r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Decodes PS/2 scan-byte prefixes into key events, with inter-byte timeout and receiver resync.
module ps2_scan_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned PAUSE_TAIL     = 7
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_byte,
   input  logic                          rx_err,
   output logic                          rx_resync,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [7:0]                    evt_code,
   output logic                          evt_ext,
   output logic                          evt_back,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          clear_overflow
);

   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SKIP_W = $clog2(PAUSE_TAIL + 1);

   ps2_seq_state_e      r_state, w_state_nxt;
   logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
   logic [SKIP_W-1:0]   r_skip, w_skip_nxt;
   logic                r_resync, w_resync_nxt;
   logic                r_overflow;
   logic                w_push;
   ps2_key_evt_t        w_push_evt;
   ps2_key_evt_t        w_head;
   logic [PS2_EVT_W-1:0] w_rd_data;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;

   assign w_pop     = evt_ready & ~w_empty;
   assign w_head    = ps2_key_evt_t'(w_rd_data);
   assign evt_valid = ~w_empty;
   assign evt_code  = w_head.code;
   assign evt_ext   = w_head.ext;
   assign evt_back  = w_head.back;
   assign rx_resync = r_resync;
   assign overflow  = r_overflow;

   // Sequence state, timeout, skip count and resync pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_tmo    <= '0;
         r_skip   <= '0;
         r_resync <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_tmo    <= w_tmo_nxt;
         r_skip   <= w_skip_nxt;
         r_resync <= w_resync_nxt;
      end
   end

   // Next-state decode: an accepted byte always beats a same-cycle timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_tmo_nxt    = r_tmo;
      w_skip_nxt   = r_skip;
      w_resync_nxt = 1'b0;
      w_push       = 1'b0;
      w_push_evt   = '0;
      if (rx_valid) begin
         w_tmo_nxt = '0;
         if (rx_err) begin
            w_state_nxt  = S_IDLE;
            w_resync_nxt = 1'b1;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (rx_byte == PS2_EXT) begin
                     w_state_nxt = S_EXT;
                  end else if (rx_byte == PS2_BRK) begin
                     w_state_nxt = S_BRK;
                  end else if (rx_byte == PS2_PAUSE) begin
                     w_state_nxt = S_PAUSE;
                     w_skip_nxt  = SKIP_W'(PAUSE_TAIL);
                  end else if (!ps2_is_status(rx_byte)) begin
                     w_push     = 1'b1;
                     w_push_evt = '{code: rx_byte, ext: 1'b0, back: 1'b0};
                  end
               end
               S_EXT: begin
                  if (rx_byte == PS2_BRK) begin
                     w_state_nxt = S_EXT_BRK;
                  end else if (rx_byte != PS2_EXT) begin
                     w_push      = 1'b1;
                     w_push_evt  = '{code: rx_byte, ext: 1'b1, back: 1'b0};
                     w_state_nxt = S_IDLE;
                  end
               end
               S_BRK: begin
                  w_push      = 1'b1;
                  w_push_evt  = '{code: rx_byte, ext: 1'b0, back: 1'b1};
                  w_state_nxt = S_IDLE;
               end
               S_EXT_BRK: begin
                  w_push      = 1'b1;
                  w_push_evt  = '{code: rx_byte, ext: 1'b1, back: 1'b1};
                  w_state_nxt = S_IDLE;
               end
               S_PAUSE: begin
                  if (r_skip <= SKIP_W'(1)) begin
                     w_skip_nxt  = '0;
                     w_push      = 1'b1;
                     w_push_evt  = '{code: PS2_PAUSE, ext: 1'b1, back: 1'b0};
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_skip_nxt = r_skip - SKIP_W'(1);
                  end
               end
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end else if (r_state == S_IDLE) begin
         w_tmo_nxt = '0;
      end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         w_tmo_nxt    = '0;
         w_state_nxt  = S_IDLE;
         w_resync_nxt = 1'b1;
      end else begin
         w_tmo_nxt = r_tmo + TMO_W'(1);
      end
   end

   // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (clear_overflow)             r_overflow <= 1'b0;
   end

   ps2_event_fifo #(
      .WIDTH (PS2_EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_push    (w_push),
      .i_data    (w_push_evt),
      .i_pop     (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (evt_count)
   );

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed self-checking bench for ps2_scan_sequencer.
module tb_ps2_scan_sequencer;

   localparam int unsigned TMO   = 100;
   localparam int unsigned DEPTH = 4;

   logic       clk;
   logic       reset_n;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_err;
   logic       rx_resync;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_back;
   logic [2:0] evt_count;
   logic       overflow;
   logic       clear_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   ps2_scan_sequencer #(
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (DEPTH),
      .PAUSE_TAIL     (7)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_valid       (rx_valid),
      .rx_byte        (rx_byte),
      .rx_err         (rx_err),
      .rx_resync      (rx_resync),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_code       (evt_code),
      .evt_ext        (evt_ext),
      .evt_back       (evt_back),
      .evt_count      (evt_count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_evt(input string tag, input logic [7:0] code, input logic ext, input logic back);
      check_eq({tag, " valid"}, 32'(evt_valid), 32'd1);
      check_eq({tag, " code"},  32'(evt_code),  32'(code));
      check_eq({tag, " ext"},   32'(evt_ext),   32'(ext));
      check_eq({tag, " back"},  32'(evt_back),  32'(back));
   endtask

   // One-cycle byte strobe; returns 1 time unit after the sampling edge.
   task automatic send(input logic [7:0] b, input logic err);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_byte  = b;
      rx_err   = err;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic pop_one();
      evt_ready = 1'b1;
      @(posedge clk);
      #1;
      evt_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] pause_seq [8];
      logic [7:0] codes [5];
      int pulses;
      int first_pulse;

      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      codes     = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

      reset_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; rx_err = 1'b0;
      evt_ready = 1'b1; clear_overflow = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst valid",    32'(evt_valid), 32'd0);
      check_eq("rst count",    32'(evt_count), 32'd0);
      check_eq("rst code",     32'(evt_code),  32'd0);
      check_eq("rst overflow", 32'(overflow),  32'd0);
      check_eq("rst resync",   32'(rx_resync), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Make / break / extended decoding
      send(8'h1C, 1'b0); check_evt("make", 8'h1C, 1'b0, 1'b0);
      send(8'hF0, 1'b0); check_eq("brk pre", 32'(evt_valid), 32'd0);
      send(8'h1C, 1'b0); check_evt("break", 8'h1C, 1'b0, 1'b1);
      send(8'hE0, 1'b0); check_eq("ext pre", 32'(evt_valid), 32'd0);
      send(8'h75, 1'b0); check_evt("ext make", 8'h75, 1'b1, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0); check_eq("extbrk pre", 32'(evt_valid), 32'd0);
      send(8'h75, 1'b0); check_evt("ext break", 8'h75, 1'b1, 1'b1);
      @(posedge clk); #1;

      // Pause: one event only after the full tail
      evt_ready = 1'b0;
      for (int i = 0; i < 7; i++) send(pause_seq[i], 1'b0);
      check_eq("pause early", 32'(evt_count), 32'd0);
      send(pause_seq[7], 1'b0);
      check_eq("pause count", 32'(evt_count), 32'd1);
      check_evt("pause", 8'hE1, 1'b1, 1'b0);
      pop_one();
      send(8'h1C, 1'b0); check_evt("post pause", 8'h1C, 1'b0, 1'b0);
      pop_one();

      // Status bytes are dropped
      evt_ready = 1'b1;
      send(8'hAA, 1'b0); check_eq("AA drop", 32'(evt_valid), 32'd0);
      send(8'hFA, 1'b0); check_eq("FA drop", 32'(evt_valid), 32'd0);
      send(8'h1C, 1'b0); check_evt("post status", 8'h1C, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Timeout after an idle gap
      send(8'hE0, 1'b0);
      pulses = 0; first_pulse = -1;
      for (int i = 1; i <= 150; i++) begin
         @(posedge clk); #1;
         if (rx_resync) begin
            pulses++;
            if (first_pulse < 0) first_pulse = i;
         end
         if (evt_valid) check_eq("tmo no evt", 32'(evt_valid), 32'd0);
      end
      check_eq("tmo pulses", 32'(pulses), 32'd1);
      check_eq("tmo cycle",  32'(first_pulse), 32'(TMO));
      send(8'h1C, 1'b0); check_evt("post tmo", 8'h1C, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Byte arriving on the terminal-count cycle still counts
      send(8'hE0, 1'b0);
      pulses = 0;
      for (int i = 0; i < int'(TMO) - 2; i++) begin
         @(posedge clk); #1;
         if (rx_resync) pulses++;
      end
      send(8'h75, 1'b0);
      check_eq("tc resync", 32'(pulses + int'(rx_resync)), 32'd0);
      check_evt("tc byte", 8'h75, 1'b1, 1'b0);
      @(posedge clk); #1;

      // Receive error aborts sequence
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b1);
      check_eq("err resync", 32'(rx_resync), 32'd1);
      check_eq("err no evt", 32'(evt_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("err pulse end", 32'(rx_resync), 32'd0);
      send(8'h1C, 1'b0); check_evt("post err", 8'h1C, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Overflow and full-FIFO behaviour
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(codes[i], 1'b0);
      check_eq("ovf count", 32'(evt_count), 32'd4);
      check_eq("ovf flag",  32'(overflow),  32'd1);
      for (int i = 0; i < 4; i++) begin
         check_eq("drain code", 32'(evt_code), 32'(codes[i]));
         pop_one();
      end
      check_eq("drained", 32'(evt_count), 32'd0);
      clear_overflow = 1'b1;
      @(posedge clk); #1;
      clear_overflow = 1'b0;
      check_eq("ovf clear", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) send(codes[i], 1'b0);
      check_eq("refill", 32'(evt_count), 32'd4);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_byte = 8'h2E; evt_ready = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; evt_ready = 1'b0;
      check_eq("full push+pop count", 32'(evt_count), 32'd4);
      check_eq("full push+pop ovf",   32'(overflow),  32'd0);
      check_eq("full push+pop head",  32'(evt_code),  32'h1E);
      for (int i = 0; i < 3; i++) pop_one();
      check_eq("wrapped tail", 32'(evt_code), 32'h2E);
      pop_one();

      // Reset mid-sequence with queued events
      send(8'h1C, 1'b0); send(8'h1B, 1'b0); send(8'h23, 1'b0);
      send(8'hE0, 1'b0);
      check_eq("pre rst count", 32'(evt_count), 32'd3);
      reset_n = 1'b0;
      #1;
      check_eq("mid rst valid", 32'(evt_valid), 32'd0);
      check_eq("mid rst count", 32'(evt_count), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      send(8'h75, 1'b0); check_evt("post rst", 8'h75, 1'b0, 1'b0);
      check_eq("post rst count", 32'(evt_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
